cache_port_arbiter: RTL and testbench
=====================================

// Module: cache_port_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer sharing the read/write port (port A) of the dual-port cache RAM between two requesters.
//  Requester 0 is the CPU data path; requester 1 is the refill/loader path.
//  Serialises accesses, drives RAM port A from registers, tracks RAM read latency, returns data plus a one-cycle ack per access.
//  RAM port B (read-only fetch port) is outside this block.
// PARAMETERS
//  DATA_WIDTH  8   RAM word width.
//  ADDR_WIDTH  14  RAM address width.
//  RD_LATENCY  2   Port A read latency: edges from the address-sampling edge to valid q; legal 1..7.
// PORTS
//  i_clk         in   1   Single clock; all logic posedge.
//  i_rst_n       in   1   Asynchronous, active-low reset.
//  i_req0/1      in   1   Request; held high with stable addr/data/write until o_ack.
//  i_write0/1    in   1   1 = write, 0 = read.
//  i_addr0/1     in   AW  Word address.
//  i_data0/1     in   DW  Write data.
//  o_data0/1     out  DW  Read data; valid with o_ack, held until the next read ack on that port.
//  o_ack0/1      out  1   One-cycle completion pulse.
//  o_ram_addr    out  AW  To RAM port A address.
//  o_ram_data    out  DW  To RAM port A write data.
//  o_ram_write   out  1   To RAM port A write.
//  o_ram_request out  1   To RAM port A request; high exactly one cycle per access.
//  i_ram_q       in   DW  RAM port A read data.
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; rr pointer=0 (req0 wins the first tie); hold regs 0.
//  FSM IDLE -> ISSUE -> [WAIT] -> CAPTURE -> IDLE. Writes go ISSUE -> IDLE.
//  IDLE: if any req, arbitrate.
//   - Single requester wins; on a tie, the requester not served last wins.
//   - Latch winner id, addr, data, write into o_ram_* regs; go to ISSUE.
//  ISSUE (1 cycle): o_ram_request=1.
//   - Write: o_ack<id> pulses in the next cycle; go to IDLE.
//   - Read: go to WAIT, or to CAPTURE if RD_LATENCY=1.
//  WAIT: 3-bit down-counter; lasts RD_LATENCY-1 cycles.
//  CAPTURE: sample i_ram_q into o_data<id>; o_ack<id>=1 next cycle; go to IDLE.
//  Latency from req seen in IDLE (cycle 0):
//   - Write ack in cycle 2.
//   - Read ack in cycle RD_LATENCY+2 (default: cycle 4).
//  Throughput: a new arbitration starts in the ack cycle (FSM is already IDLE).
//   - Back-to-back writes: one per 2 cycles.
//   - Reads: one per RD_LATENCY+2 cycles.
//  rr pointer updates on grant; o_ram_addr/data/write hold their last value outside ISSUE.
//  Simultaneous events:
//   - Both reqs held continuously -> strict alternation 0,1,0,1.
//   - The non-granted req simply waits; there is no timeout.
//  Req dropped mid-access: the access still completes and the ack still pulses; the requester ignores it.
//  Req held after ack: treated as a new request (re-arbitrated).
//  Reset asserted mid-operation:
//   - o_ram_request clears immediately, so a write in ISSUE is suppressed.
//   - Any pending ack is lost; FSM restarts in IDLE.
// CONFIGURATION
//  CACHE_ARB_PERF_EN defined:
//   - Adds out ports o_grants0/o_grants1 (16 bits each): saturating per-requester grant counters.
//   - Adds out port o_conflicts (16 bits): saturating count of IDLE cycles with both reqs high.
//   - All three cleared by reset.
//  Not defined: ports and counters absent; core behaviour identical.
// TESTING
//  T1 Single read:
//   - Setup: RAM[0x0010]=0xA5.
//   - Stimulus: req0 read 0x0010, RD_LATENCY=2.
//   - Required: o_ram_request cycle 1 only; o_ack0 and o_data0=0xA5 in cycle 4.
//  T2 Single write:
//   - Stimulus: req1 write 0x3FFF=0x5A.
//   - Required: o_ack1 in cycle 2. A following read of 0x3FFF returns 0x5A.
//  T3 Tie:
//   - Stimulus: req0 and req1 reads both raised in the same cycle after reset.
//   - Required: req0 acked first; req1 acked RD_LATENCY+2 cycles later; o_ack0/o_ack1 never high together.
//  T4 Starvation check:
//   - Stimulus: both reqs held for 8 writes.
//   - Required: grant order 0,1,0,1,...; exactly 4 acks each.
//  T5 Reset in ISSUE:
//   - Stimulus: i_rst_n pulled low during the ISSUE cycle of a write of 0xFF to 0x0001.
//   - Required: RAM[0x0001] unchanged; no ack; all outputs 0.
//  T6 PERF build:
//   - Stimulus: T4 with CACHE_ARB_PERF_EN.
//   - Required: o_grants0=4, o_grants1=4; o_conflicts>=1.

Source files
------------

// File: rtl/cache_port_arbiter_if.sv
// Bundles the two requester ports and the RAM port A bus driven by cache_port_arbiter.
// slave: the arbiter side; master: requesters plus RAM model.
interface cache_port_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 14
);
    logic                  i_req0,   i_req1;
    logic                  i_write0, i_write1;
    logic [ADDR_WIDTH-1:0] i_addr0,  i_addr1;
    logic [DATA_WIDTH-1:0] i_data0,  i_data1;
    logic [DATA_WIDTH-1:0] o_data0,  o_data1;
    logic                  o_ack0,   o_ack1;
    logic [ADDR_WIDTH-1:0] o_ram_addr;
    logic [DATA_WIDTH-1:0] o_ram_data;
    logic                  o_ram_write;
    logic                  o_ram_request;
    logic [DATA_WIDTH-1:0] i_ram_q;

    modport slave (
        input  i_req0, i_req1, i_write0, i_write1, i_addr0, i_addr1, i_data0, i_data1, i_ram_q,
        output o_data0, o_data1, o_ack0, o_ack1,
        output o_ram_addr, o_ram_data, o_ram_write, o_ram_request
    );

    modport master (
        output i_req0, i_req1, i_write0, i_write1, i_addr0, i_addr1, i_data0, i_data1, i_ram_q,
        input  o_data0, o_data1, o_ack0, o_ack1,
        input  o_ram_addr, o_ram_data, o_ram_write, o_ram_request
    );
endinterface

// File: rtl/cache_port_arbiter.sv
// Round-robin sequencer sharing RAM port A between CPU (req0) and refill (req1).
// Optional perf counters enabled by defining CACHE_ARB_PERF_EN.

// Per-requester return path: registered ack pulse and held read data.
module cache_port_arbiter_lane #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_fire,
    input  logic                  i_cap,
    input  logic [DATA_WIDTH-1:0] i_q,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_ack
);
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_data <= '0;
            o_ack  <= 1'b0;
        end else begin
            o_ack <= i_fire;
            if (i_cap) o_data <= i_q;
        end
    end
endmodule

module cache_port_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 14,
    parameter int RD_LATENCY = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
`ifdef CACHE_ARB_PERF_EN
    output logic [15:0] o_grants0,
    output logic [15:0] o_grants1,
    output logic [15:0] o_conflicts,
`endif
    cache_port_arbiter_if.slave bus
);
    localparam int NUM_REQ = 2;
    // WAIT spans RD_LATENCY-1 cycles, so the counter starts one below that.
    localparam logic [2:0] WAIT_INIT = (RD_LATENCY >= 2) ? 3'(RD_LATENCY - 2) : 3'd0;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CAPTURE} state_t;

    logic [NUM_REQ-1:0]                 req, wr, fire, cap;
    logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] addr;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] wdata, rdata;
    logic [NUM_REQ-1:0]                 ack;

    state_t                state;
    logic                  gnt_id, rr_ptr, win;
    logic [2:0]            wait_cnt;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_data;
    logic                  ram_write, ram_request;

    assign req   = {bus.i_req1,   bus.i_req0};
    assign wr    = {bus.i_write1, bus.i_write0};
    assign addr  = {bus.i_addr1,  bus.i_addr0};
    assign wdata = {bus.i_data1,  bus.i_data0};

    assign bus.o_data0       = rdata[0];
    assign bus.o_data1       = rdata[1];
    assign bus.o_ack0        = ack[0];
    assign bus.o_ack1        = ack[1];
    assign bus.o_ram_addr    = ram_addr;
    assign bus.o_ram_data    = ram_data;
    assign bus.o_ram_write   = ram_write;
    assign bus.o_ram_request = ram_request;

    // rr_ptr names the requester that wins a tie; a lone requester always wins.
    always_comb begin
        win = req[1];
        if (&req) win = rr_ptr;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            gnt_id      <= 1'b0;
            rr_ptr      <= 1'b0;
            wait_cnt    <= '0;
            ram_addr    <= '0;
            ram_data    <= '0;
            ram_write   <= 1'b0;
            ram_request <= 1'b0;
        end else begin
            ram_request <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        gnt_id      <= win;
                        rr_ptr      <= ~win;
                        ram_addr    <= addr[win];
                        ram_data    <= wdata[win];
                        ram_write   <= wr[win];
                        ram_request <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (ram_write) begin
                        state <= IDLE;
                    end else if (RD_LATENCY == 1) begin
                        state <= CAPTURE;
                    end else begin
                        wait_cnt <= WAIT_INIT;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt == 3'd0) state <= CAPTURE;
                    else                  wait_cnt <= wait_cnt - 3'd1;
                end
                CAPTURE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
        assign cap[g]  = (gnt_id == 1'(g)) && (state == CAPTURE);
        assign fire[g] = cap[g] || ((gnt_id == 1'(g)) && (state == ISSUE) && ram_write);

        cache_port_arbiter_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_fire  (fire[g]),
            .i_cap   (cap[g]),
            .i_q     (bus.i_ram_q),
            .o_data  (rdata[g]),
            .o_ack   (ack[g])
        );
    end

`ifdef CACHE_ARB_PERF_EN
    logic [NUM_REQ-1:0][15:0] grants;
    logic [15:0]              conflicts;

    assign o_grants0   = grants[0];
    assign o_grants1   = grants[1];
    assign o_conflicts = conflicts;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            grants    <= '0;
            conflicts <= '0;
        end else if (state == IDLE) begin
            if ((|req) && (grants[win] != 16'hFFFF)) grants[win] <= grants[win] + 16'd1;
            if ((&req) && (conflicts != 16'hFFFF))   conflicts   <= conflicts + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Directed bench for cache_port_arbiter: vector table of single accesses plus
// tie, alternation, reset-in-ISSUE and (optionally) perf-counter sequences.
module tb_cache_port_arbiter;
    localparam int DW  = 8;
    localparam int AW  = 14;
    localparam int RDL = 2;

    logic i_clk = 1'b0;
    logic i_rst_n = 1'b0;
    always #5 i_clk = ~i_clk;

    cache_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

`ifdef CACHE_ARB_PERF_EN
    logic [15:0] grants0, grants1, conflicts;
`endif

    cache_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(RDL)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
`ifdef CACHE_ARB_PERF_EN
        .o_grants0   (grants0),
        .o_grants1   (grants1),
        .o_conflicts (conflicts),
`endif
        .bus         (bus)
    );

    // RAM port A model: write on request, read data valid RDL edges later.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] q_pipe [0:RDL-1];
    always @(posedge i_clk) begin
        if (bus.o_ram_request) begin
            if (bus.o_ram_write) mem[bus.o_ram_addr] = bus.o_ram_data;
            else                 q_pipe[0] <= mem[bus.o_ram_addr];
        end
        for (int k = 1; k < RDL; k++) q_pipe[k] <= q_pipe[k-1];
    end
    assign bus.i_ram_q = q_pipe[RDL-1];

    int total = 0;
    int bad   = 0;
    int dual_ack  = 0;
    int ack_total = 0;

    always @(negedge i_clk) begin
        if (i_rst_n) begin
            if (bus.o_ack0 && bus.o_ack1) dual_ack++;
            if (bus.o_ack0) ack_total++;
            if (bus.o_ack1) ack_total++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_req(input logic id, input logic r, input logic w,
                             input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (id == 1'b0) begin
            bus.i_req0 = r; bus.i_write0 = w; bus.i_addr0 = a; bus.i_data0 = d;
        end else begin
            bus.i_req1 = r; bus.i_write1 = w; bus.i_addr1 = a; bus.i_data1 = d;
        end
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        bus.i_req0 = 1'b0;
        bus.i_req1 = 1'b0;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    // Raises one request before the cycle-0 edge and counts edges until its ack.
    task automatic access(input logic id, input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, output int lat, output logic [DW-1:0] rd,
                          output int rq_cnt, output int rq_cyc);
        lat = -1; rd = '0; rq_cnt = 0; rq_cyc = -1;
        @(negedge i_clk);
        drive_req(id, 1'b1, w, a, d);
        for (int n = 1; n <= 30; n++) begin
            @(posedge i_clk); #1;
            if (bus.o_ram_request) begin rq_cnt++; rq_cyc = n; end
            if ((id == 1'b0 && bus.o_ack0) || (id == 1'b1 && bus.o_ack1)) begin
                lat = n;
                rd  = (id == 1'b0) ? bus.o_data0 : bus.o_data1;
                drive_req(id, 1'b0, w, a, d);
                break;
            end
        end
        drive_req(id, 1'b0, w, a, d);
    endtask

    typedef struct {
        logic          id;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_q;
        int            exp_lat;
    } vec_t;

    vec_t vt [6];

    initial begin
        int lat, rq_cnt, rq_cyc, a0, a1, acks_before;
        logic [DW-1:0] rd;
        int order [$];
        int ack_cyc [$];

        for (int k = 0; k < (1<<AW); k++) mem[k] = '0;
        mem[14'h0010] = 8'hA5;
        mem[14'h0200] = 8'h3C;
        mem[14'h0001] = 8'h33;
        for (int k = 0; k < RDL; k++) q_pipe[k] = '0;

        vt[0] = '{1'b0, 1'b0, 14'h0010, 8'h00, 8'hA5, RDL + 2};
        vt[1] = '{1'b1, 1'b1, 14'h3FFF, 8'h5A, 8'h00, 2};
        vt[2] = '{1'b0, 1'b0, 14'h3FFF, 8'h00, 8'h5A, RDL + 2};
        vt[3] = '{1'b1, 1'b0, 14'h0200, 8'h00, 8'h3C, RDL + 2};
        vt[4] = '{1'b0, 1'b1, 14'h0000, 8'h77, 8'h00, 2};
        vt[5] = '{1'b1, 1'b0, 14'h0000, 8'h00, 8'h77, RDL + 2};

        drive_req(1'b0, 1'b0, 1'b0, '0, '0);
        drive_req(1'b1, 1'b0, 1'b0, '0, '0);
        do_reset();

        #1;
        check("rst_ack0",  32'(bus.o_ack0), 0);
        check("rst_ack1",  32'(bus.o_ack1), 0);
        check("rst_data0", 32'(bus.o_data0), 0);
        check("rst_data1", 32'(bus.o_data1), 0);
        check("rst_ram_addr", 32'(bus.o_ram_addr), 0);
        check("rst_ram_wr_rq", 32'({bus.o_ram_write, bus.o_ram_request}), 0);

        for (int i = 0; i < 6; i++) begin
            access(vt[i].id, vt[i].wr, vt[i].addr, vt[i].wdata, lat, rd, rq_cnt, rq_cyc);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(vt[i].exp_lat));
            check($sformatf("v%0d_req_pulses", i), 32'(rq_cnt), 1);
            check($sformatf("v%0d_req_cycle", i), 32'(rq_cyc), 1);
            if (!vt[i].wr) check($sformatf("v%0d_rdata", i), 32'(rd), 32'(vt[i].exp_q));
            else           check($sformatf("v%0d_mem", i), 32'(mem[vt[i].addr]), 32'(vt[i].wdata));
        end
        check("hold_data0", 32'(bus.o_data0), 32'h5A);
        check("hold_data1", 32'(bus.o_data1), 32'h77);

        // Tie right after reset: req0 first, req1 one read period later.
        do_reset();
        a0 = -1; a1 = -1;
        @(negedge i_clk);
        drive_req(1'b0, 1'b1, 1'b0, 14'h0010, '0);
        drive_req(1'b1, 1'b1, 1'b0, 14'h0200, '0);
        for (int n = 1; n <= 20; n++) begin
            @(posedge i_clk); #1;
            if (bus.o_ack0 && a0 < 0) begin a0 = n; bus.i_req0 = 1'b0; end
            if (bus.o_ack1 && a1 < 0) begin a1 = n; bus.i_req1 = 1'b0; end
            if (a0 >= 0 && a1 >= 0) break;
        end
        bus.i_req0 = 1'b0; bus.i_req1 = 1'b0;
        check("tie_ack0_cycle", 32'(a0), RDL + 2);
        check("tie_ack1_cycle", 32'(a1), 2 * (RDL + 2));
        check("tie_data0", 32'(bus.o_data0), 32'hA5);
        check("tie_data1", 32'(bus.o_data1), 32'h3C);

        // Both writers held continuously: strict alternation, one ack per 2 cycles.
        do_reset();
        @(negedge i_clk);
        drive_req(1'b0, 1'b1, 1'b1, 14'h0100, 8'h11);
        drive_req(1'b1, 1'b1, 1'b1, 14'h0101, 8'h22);
        for (int n = 1; n <= 40; n++) begin
            @(posedge i_clk); #1;
            if (bus.o_ack0) begin order.push_back(0); ack_cyc.push_back(n); end
            if (bus.o_ack1) begin order.push_back(1); ack_cyc.push_back(n); end
            if (order.size() >= 8) break;
        end
        bus.i_req0 = 1'b0; bus.i_req1 = 1'b0;
        check("alt_ack_count", 32'(order.size()), 8);
        for (int i = 0; i < order.size() && i < 8; i++)
            check($sformatf("alt_order_%0d", i), 32'(order[i]), 32'(i % 2));
        if (ack_cyc.size() >= 8) check("alt_last_ack_cycle", 32'(ack_cyc[7]), 16);
        check("alt_mem0", 32'(mem[14'h0100]), 32'h11);
        check("alt_mem1", 32'(mem[14'h0101]), 32'h22);
`ifdef CACHE_ARB_PERF_EN
        @(negedge i_clk);
        check("perf_grants0", 32'(grants0), 4);
        check("perf_grants1", 32'(grants1), 4);
        check("perf_conflicts_nonzero", 32'(conflicts != 16'd0), 1);
`endif

        // Reset asserted while the write sits in ISSUE.
        do_reset();
        @(negedge i_clk);
        drive_req(1'b0, 1'b1, 1'b1, 14'h0001, 8'hFF);
        @(posedge i_clk); #1;
        check("rst_issue_req_seen", 32'(bus.o_ram_request), 1);
        acks_before = ack_total;
        i_rst_n = 1'b0;
        #1;
        check("rst_issue_outputs", 32'({bus.o_ram_request, bus.o_ram_write, bus.o_ack0, bus.o_ack1}), 0);
        check("rst_issue_addr_data", 32'({bus.o_ram_addr, bus.o_ram_data}), 0);
        bus.i_req0 = 1'b0;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (4) @(posedge i_clk);
        #1;
        check("rst_issue_mem", 32'(mem[14'h0001]), 32'h33);
        check("rst_issue_no_ack", 32'(ack_total - acks_before), 0);
        check("no_dual_ack", 32'(dual_ack), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
